intersection_scheduler: RTL and testbench



---
 rtl/intersection_scheduler.sv | 114 +++++++++++
 tb/tb_intersection_scheduler.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/intersection_scheduler.sv
// Two-approach intersection scheduler: one elapsed counter plus a direction bit
// sequence all-red, green, yellow and pedestrian-walk phases.
//
// state  | meaning
// ALLRED | both approaches red, clearance before the dir approach gets green
// GREEN  | dir approach green, other red; may exit early after minimum green
// YELLOW | dir approach yellow, other red; exits to WALK if a pedestrian waits
// WALK   | both approaches red, walk lamp on
module intersection_scheduler #(
  parameter int CNT_W         = 16,
  parameter int GREEN_CYC     = 700,
  parameter int MIN_GREEN_CYC = 200,
  parameter int YELLOW_CYC    = 50,
  parameter int ALLRED_CYC    = 100,
  parameter int WALK_CYC      = 500
) (
  input  logic clk,
  input  logic rst_n,
  input  logic car_a,
  input  logic car_b,
  input  logic ped_req,
  output logic a_green,
  output logic a_yellow,
  output logic a_red,
  output logic b_green,
  output logic b_yellow,
  output logic b_red,
  output logic walk,
  output logic ped_wait
);

  typedef enum logic [1:0] {ALLRED, GREEN, YELLOW, WALK} phase_t;

  localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(ALLRED_CYC - 1);
  localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(GREEN_CYC - 1);
  localparam logic [CNT_W-1:0] MIN_LAST    = CNT_W'(MIN_GREEN_CYC - 1);
  localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_CYC - 1);
  localparam logic [CNT_W-1:0] WALK_LAST   = CNT_W'(WALK_CYC - 1);

  phase_t           phase, phase_nx;
  logic             dir, dir_nx;
  logic [CNT_W-1:0] elapsed;
  logic             ped_wait_nx;
  logic             other_demand;
  logic             yellow_done;

  assign other_demand = (dir ? car_a : car_b) | ped_wait;
  assign yellow_done  = (phase == YELLOW) && (elapsed == YELLOW_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase    <= ALLRED;
      dir      <= 1'b0;
      elapsed  <= '0;
      ped_wait <= 1'b0;
    end else begin
      phase    <= phase_nx;
      dir      <= dir_nx;
      ped_wait <= ped_wait_nx;
      if (phase_nx != phase) elapsed <= '0;
      else                   elapsed <= elapsed + CNT_W'(1);
    end
  end

  always_comb begin
    phase_nx = phase;
    dir_nx   = dir;
    case (phase)
      ALLRED: if (elapsed == ALLRED_LAST) phase_nx = GREEN;
      GREEN: begin
        if ((elapsed == GREEN_LAST) || ((elapsed >= MIN_LAST) && other_demand))
          phase_nx = YELLOW;
      end
      YELLOW: begin
        if (yellow_done) begin
          phase_nx = ped_wait ? WALK : ALLRED;
          dir_nx   = ~dir;
        end
      end
      WALK: if (elapsed == WALK_LAST) phase_nx = ALLRED;
      default: phase_nx = ALLRED;
    endcase
  end

  // Entering WALK serves the pending request, even if the button is still held.
  always_comb begin
    ped_wait_nx = ped_wait;
    if (yellow_done && ped_wait)        ped_wait_nx = 1'b0;
    else if (phase != WALK && ped_req)  ped_wait_nx = 1'b1;
  end

  always_comb begin
    a_green  = 1'b0;
    a_yellow = 1'b0;
    a_red    = 1'b1;
    b_green  = 1'b0;
    b_yellow = 1'b0;
    b_red    = 1'b1;
    walk     = 1'b0;
    case (phase)
      GREEN: begin
        if (dir) begin b_green = 1'b1; b_red = 1'b0; end
        else     begin a_green = 1'b1; a_red = 1'b0; end
      end
      YELLOW: begin
        if (dir) begin b_yellow = 1'b1; b_red = 1'b0; end
        else     begin a_yellow = 1'b1; a_red = 1'b0; end
      end
      WALK:    walk = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_intersection_scheduler.sv
// Table-driven bench for intersection_scheduler: per-cycle input/expected-lamp
// vectors, with expected values queued at drive time and popped at sampling.
module tb_intersection_scheduler;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic car_a = 1'b0, car_b = 1'b0, ped_req = 1'b0;
  logic a_green, a_yellow, a_red, b_green, b_yellow, b_red, walk, ped_wait;

  intersection_scheduler #(
    .CNT_W(16), .GREEN_CYC(8), .MIN_GREEN_CYC(3), .YELLOW_CYC(2),
    .ALLRED_CYC(1), .WALK_CYC(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .car_a(car_a), .car_b(car_b), .ped_req(ped_req),
    .a_green(a_green), .a_yellow(a_yellow), .a_red(a_red),
    .b_green(b_green), .b_yellow(b_yellow), .b_red(b_red),
    .walk(walk), .ped_wait(ped_wait)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       ca, cb, pr;
    byte        code;   // R all red, A/a A green/yellow, B/b B green/yellow, W walk
    logic       pw;
  } vec_t;

  vec_t       tbl[$];
  logic [7:0] sb[$];
  int         n_vec = 0;
  int         n_miss = 0;

  // {a_g, a_y, a_r, b_g, b_y, b_r, walk, ped_wait}
  function automatic logic [7:0] expect_bits(byte code, logic pw);
    logic [6:0] l;
    case (code)
      "A":     l = 7'b1000010;
      "a":     l = 7'b0100010;
      "B":     l = 7'b0011000;
      "b":     l = 7'b0010100;
      "W":     l = 7'b0010011;
      default: l = 7'b0010010;
    endcase
    return {l, pw};
  endfunction

  function automatic void add(int n, logic ca, logic cb, logic pr, byte code, logic pw);
    vec_t v;
    v.ca = ca; v.cb = cb; v.pr = pr; v.code = code; v.pw = pw;
    for (int i = 0; i < n; i++) tbl.push_back(v);
  endfunction

  function automatic logic [7:0] dut_bits();
    return {a_green, a_yellow, a_red, b_green, b_yellow, b_red, walk, ped_wait};
  endfunction

  task automatic check(string name, logic [7:0] exp);
    n_vec++;
    if (dut_bits() !== exp) begin
      n_miss++;
      $display("FAIL %s: lamps/ped_wait got %b expected %b at %0t", name, dut_bits(), exp, $time);
    end
  endtask

  // Leaves the bench #1 after a rising edge, with the DUT in ALLRED elapsed 0.
  task automatic do_reset();
    rst_n = 1'b0; car_a = 1'b0; car_b = 1'b0; ped_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Each vector: drive inputs for this cycle, queue expected, compare at negedge.
  task automatic run(string name);
    logic [7:0] exp;
    for (int i = 0; i < tbl.size(); i++) begin
      car_a = tbl[i].ca; car_b = tbl[i].cb; ped_req = tbl[i].pr;
      sb.push_back(expect_bits(tbl[i].code, tbl[i].pw));
      @(negedge clk);
      exp = sb.pop_front();
      check($sformatf("%s[%0d]", name, i), exp);
      @(posedge clk);
      #1;
    end
    tbl.delete();
  endtask

  initial begin
    // Idle: full period of 22 cycles with max-out greens, back to A.
    do_reset();
    add(1, 0, 0, 0, "R", 0); add(8, 0, 0, 0, "A", 0); add(2, 0, 0, 0, "a", 0);
    add(1, 0, 0, 0, "R", 0); add(8, 0, 0, 0, "B", 0); add(2, 0, 0, 0, "b", 0);
    add(1, 0, 0, 0, "R", 0); add(8, 0, 0, 0, "A", 0);
    run("idle");

    // car_b held from A green entry: minimum green, then B gets full green.
    do_reset();
    add(1, 0, 0, 0, "R", 0); add(3, 0, 1, 0, "A", 0); add(2, 0, 1, 0, "a", 0);
    add(1, 0, 1, 0, "R", 0); add(8, 0, 1, 0, "B", 0); add(2, 0, 1, 0, "b", 0);
    add(1, 0, 1, 0, "R", 0); add(3, 0, 1, 0, "A", 0); add(1, 0, 0, 0, "a", 0);
    run("car_b");

    // Pedestrian pulse so that ped_wait is set at A-green elapsed 5.
    do_reset();
    add(1, 0, 0, 0, "R", 0); add(4, 0, 0, 0, "A", 0); add(1, 0, 0, 1, "A", 0);
    add(1, 0, 0, 0, "A", 1); add(2, 0, 0, 0, "a", 1); add(4, 0, 0, 0, "W", 0);
    add(1, 0, 0, 0, "R", 0); add(8, 0, 0, 0, "B", 0); add(1, 0, 0, 0, "b", 0);
    run("ped_pulse");

    // Button held over the YELLOW->WALK edge and all of WALK: clear wins, then ignored.
    do_reset();
    add(1, 0, 0, 0, "R", 0); add(4, 0, 0, 0, "A", 0); add(1, 0, 0, 1, "A", 0);
    add(1, 0, 0, 0, "A", 1); add(1, 0, 0, 0, "a", 1); add(1, 0, 0, 1, "a", 1);
    add(4, 0, 0, 1, "W", 0); add(1, 0, 0, 0, "R", 0); add(8, 0, 0, 0, "B", 0);
    run("ped_hold");

    // Short demand before minimum green has no effect.
    do_reset();
    add(1, 0, 0, 0, "R", 0); add(2, 0, 1, 0, "A", 0); add(6, 0, 0, 0, "A", 0);
    add(2, 0, 0, 0, "a", 0); add(1, 0, 0, 0, "R", 0); add(8, 0, 0, 0, "B", 0);
    run("short_demand");

    // car_a during B green also exits early (dir=1 demand path).
    do_reset();
    add(1, 0, 0, 0, "R", 0); add(8, 0, 0, 0, "A", 0); add(2, 0, 0, 0, "a", 0);
    add(1, 0, 0, 0, "R", 0); add(3, 1, 0, 0, "B", 0); add(2, 1, 0, 0, "b", 0);
    add(1, 0, 0, 0, "R", 0); add(1, 0, 0, 0, "A", 0);
    run("car_a");

    // Asynchronous reset at B-green elapsed 4 with ped_wait pending.
    do_reset();
    add(1, 0, 0, 0, "R", 0); add(8, 0, 0, 0, "A", 0); add(2, 0, 0, 0, "a", 0);
    add(1, 0, 0, 0, "R", 0); add(3, 0, 0, 0, "B", 0); add(1, 0, 0, 1, "B", 0);
    run("pre_reset");
    ped_req = 1'b0;
    @(negedge clk);
    check("b_green_e4", expect_bits("B", 1));
    #1 rst_n = 1'b0;
    #1 check("async_reset", expect_bits("R", 0));
    @(posedge clk);
    #1 check("reset_hold", expect_bits("R", 0));
    rst_n = 1'b1;
    add(1, 0, 0, 0, "R", 0); add(3, 0, 0, 0, "A", 0);
    run("post_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete, got running expected done");
    $fatal(1, "timeout");
  end

endmodule
